// File: rtl/step_counter_pkg.sv
// rtl/step_counter_pkg.sv - shared mode encoding for step_counter
//
// Purpose : increment-pattern encoding shared by the counter, its
//           next-value logic and its interface.
// Contents: mode_t (2-bit mode), MODE_UNIT, MODE_STEP, MODE_WARMUP.
//           Encoding 3 is reserved and treated like MODE_UNIT.
package step_counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UNIT   = 2'd0;
  localparam mode_t MODE_STEP   = 2'd1;
  localparam mode_t MODE_WARMUP = 2'd2;

endpackage

// File: rtl/step_counter_if.sv
// rtl/step_counter_if.sv - control/status bundle for step_counter
//
// Purpose : groups the counter controls and status outputs.
// Signals : en, load, load_val[WIDTH], limit[WIDTH], mode, dir  (master -> slave)
//           cnt[WIDTH], wrap, at_limit                        (slave -> master)
// Modports: master (controller side), slave (counter side).
interface step_counter_if #(
  parameter int WIDTH = 4
);
  import step_counter_pkg::*;

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  mode_t            mode;
  logic             dir;
  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             at_limit;

  modport master (
    output en, load, load_val, limit, mode, dir,
    input  cnt, wrap, at_limit
  );

  modport slave (
    input  en, load, load_val, limit, mode, dir,
    output cnt, wrap, at_limit
  );

endinterface

// File: rtl/step_counter_next.sv
// rtl/step_counter_next.sv - combinational next count and wrap for step_counter
//
// Purpose : computes the value cnt takes on an enabled edge and whether
//           that edge is a wrap-around.
// Ports   : cnt_i    current count
//           limit_i  terminal value
//           mode_i   increment pattern
//           dir_i    0 = up, 1 = down (used only with STEP_COUNTER_DOWN_EN)
//           cnt_d_o  next count
//           wrap_d_o next wrap pulse
// Macro   : STEP_COUNTER_DOWN_EN builds the down-count path.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] limit_i,
  input  mode_t            mode_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] cnt_d_o,
  output logic             wrap_d_o
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] TWO_W  = (WIDTH+1)'(2);

  // One extra bit so cnt + inc cannot overflow before the limit compare.
  logic [WIDTH:0]   cnt_w;
  logic [WIDTH:0]   limit_w;
  logic [WIDTH:0]   inc_up;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] up_cnt;
  logic             up_wrap;

  assign cnt_w   = {1'b0, cnt_i};
  assign limit_w = {1'b0, limit_i};

  // Warm-up pattern takes two +1 steps (0->1->2) before switching to STEP.
  always_comb begin
    inc_up = ONE_W;
    if (mode_i == MODE_STEP || (mode_i == MODE_WARMUP && cnt_w >= TWO_W)) begin
      inc_up = STEP_W;
    end
  end

  assign sum_up = cnt_w + inc_up;

  // Overshoot clamps to limit so the terminal value is always visited.
  always_comb begin
    up_cnt  = '0;
    up_wrap = 1'b0;
    if (cnt_i >= limit_i) begin
      up_cnt  = '0;
      up_wrap = 1'b1;
    end else if (sum_up > limit_w) begin
      up_cnt = limit_i;
    end else begin
      up_cnt = sum_up[WIDTH-1:0];
    end
  end

`ifdef STEP_COUNTER_DOWN_EN
  logic [WIDTH:0]   inc_dn;
  logic [WIDTH:0]   diff_dn;
  logic [WIDTH-1:0] dn_cnt;
  logic             dn_wrap;

  // Warm-up has no meaning going down; it uses the large step.
  assign inc_dn  = (mode_i == MODE_STEP || mode_i == MODE_WARMUP) ? STEP_W : ONE_W;
  assign diff_dn = cnt_w - inc_dn;

  // Counts above limit (e.g. after a load) re-enter at limit, like a wrap.
  always_comb begin
    dn_cnt  = '0;
    dn_wrap = 1'b0;
    if (cnt_i == '0 || cnt_i > limit_i) begin
      dn_cnt  = limit_i;
      dn_wrap = 1'b1;
    end else if (cnt_w <= inc_dn) begin
      dn_cnt = '0;
    end else begin
      dn_cnt = diff_dn[WIDTH-1:0];
    end
  end

  assign cnt_d_o  = dir_i ? dn_cnt  : up_cnt;
  assign wrap_d_o = dir_i ? dn_wrap : up_wrap;
`else
  logic unused_dir;
  assign unused_dir = dir_i;

  assign cnt_d_o  = up_cnt;
  assign wrap_d_o = up_wrap;
`endif

endmodule

// File: rtl/step_counter.sv
// rtl/step_counter.sv - programmable-sequence counter with wrap pulse
//
// Purpose : counts 0..limit with a selectable increment pattern, supports
//           synchronous load, enable gating and a registered wrap pulse.
// Ports   : clk    rising-edge clock
//           reset  synchronous, active-high, highest priority
//           bus    step_counter_if.slave (en, load, load_val, limit, mode,
//                  dir in; cnt, wrap, at_limit out)
// Macro   : STEP_COUNTER_DOWN_EN enables the down direction via bus.dir.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 2
) (
  input  logic           clk,
  input  logic           reset,
  step_counter_if.slave  bus
);

  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_d;

  step_counter_next #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next (
    .cnt_i    (cnt_q),
    .limit_i  (bus.limit),
    .mode_i   (bus.mode),
    .dir_i    (bus.dir),
    .cnt_d_o  (cnt_d),
    .wrap_d_o (wrap_d)
  );

  // COUNT/TERMINAL state lives in cnt_q itself; priority reset > load > en > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q  <= bus.load_val;
      wrap_q <= 1'b0;
    end else if (bus.en) begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_limit = (cnt_q == bus.limit);

endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - self-checking bench for step_counter
module tb_step_counter;
  import step_counter_pkg::*;

  localparam int W    = 4;
  localparam int STEP = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  step_counter_if #(.WIDTH(W)) bus ();

  step_counter #(.WIDTH(W), .STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int m_cnt   = 0;
  int m_wrap  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                       input int lim, input int md, input bit d);
    reset        = r;
    bus.load     = ld;
    bus.load_val = W'(lv);
    bus.en       = e;
    bus.limit    = W'(lim);
    bus.mode     = mode_t'(md);
    bus.dir      = d;
  endtask

  // Reference: the counter's rules applied to integers.
  task automatic model_edge();
    int lim, md, inc, s;
    lim = int'(bus.limit);
    md  = int'(bus.mode);
    if (reset) begin
      m_cnt = 0; m_wrap = 0;
    end else if (bus.load) begin
      m_cnt = int'(bus.load_val); m_wrap = 0;
    end else if (!bus.en) begin
      m_wrap = 0;
`ifdef STEP_COUNTER_DOWN_EN
    end else if (bus.dir) begin
      inc = (md == 1 || md == 2) ? STEP : 1;
      if (m_cnt == 0 || m_cnt > lim) begin
        m_cnt = lim; m_wrap = 1;
      end else begin
        m_cnt = (m_cnt - inc < 0) ? 0 : m_cnt - inc; m_wrap = 0;
      end
`endif
    end else if (m_cnt >= lim) begin
      m_cnt = 0; m_wrap = 1;
    end else begin
      inc    = (md == 1 || (md == 2 && m_cnt >= 2)) ? STEP : 1;
      s      = m_cnt + inc;
      m_cnt  = (s > lim) ? lim : s;
      m_wrap = 0;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".cnt"},      int'(bus.cnt),      m_cnt);
    check({tag, ".wrap"},     int'(bus.wrap),     m_wrap);
    check({tag, ".at_limit"}, int'(bus.at_limit), int'(m_cnt == int'(bus.limit)));
  endtask

  int exp_warm[9] = '{1, 2, 4, 6, 8, 10, 12, 14, 0};
  int exp_step[8] = '{2, 4, 6, 8, 10, 12, 13, 0};

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    tick("reset");
    check("reset.cnt0", int'(bus.cnt), 0);

    // Warm-up pattern, limit 14, against a literal sequence.
    drive(0, 0, 0, 1, 14, 2, 0);
    for (int i = 0; i < 9; i++) begin
      tick("warm");
      check($sformatf("warm_seq[%0d]", i), int'(bus.cnt), exp_warm[i]);
      check($sformatf("warm_wrap[%0d]", i), int'(bus.wrap), int'(i == 8));
      check($sformatf("warm_atl[%0d]", i), int'(bus.at_limit), int'(i == 7));
    end

    // Large step with clamp at 13.
    drive(0, 0, 0, 1, 13, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick("step");
      check($sformatf("step_seq[%0d]", i), int'(bus.cnt), exp_step[i]);
      check($sformatf("step_wrap[%0d]", i), int'(bus.wrap), int'(i == 7));
    end

    // Load above limit, then wrap; load overrides en.
    drive(0, 1, 15, 0, 9, 0, 0);
    tick("load15");
    check("load15.val", int'(bus.cnt), 15);
    drive(0, 0, 0, 1, 9, 0, 0);
    tick("load_wrap");
    check("load_wrap.val", int'(bus.cnt), 0);
    check("load_wrap.pulse", int'(bus.wrap), 1);
    drive(0, 1, 7, 1, 9, 0, 0);
    tick("load_en");
    check("load_en.val", int'(bus.cnt), 7);

    // en toggling in mode 0, then reset mid-count beats load and en.
    drive(0, 1, 0, 0, 3, 0, 0);
    tick("zero");
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, i[0] == 1'b0, 3, 0, 0);
      tick("toggle");
    end
    drive(0, 0, 0, 1, 3, 0, 0);
    tick("pre_rst");
    drive(1, 1, 9, 1, 3, 0, 0);
    tick("mid_rst");
    check("mid_rst.cnt", int'(bus.cnt), 0);
    check("mid_rst.wrap", int'(bus.wrap), 0);

    // Limit 0: wrap every cycle, then resume with limit 5.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      tick("lim0");
      check("lim0.wrap_const", int'(bus.wrap), 1);
    end
    drive(0, 0, 0, 1, 5, 0, 0);
    tick("lim5");
    check("lim5.cnt", int'(bus.cnt), 1);

`ifdef STEP_COUNTER_DOWN_EN
    drive(0, 1, 0, 0, 7, 1, 1);
    tick("dn_start");
    drive(0, 0, 0, 1, 7, 1, 1);
    for (int i = 0; i < 6; i++) tick("down");
`endif

    // Randomized traffic against the model.
    begin
      int lim, md;
      lim = 9; md = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(7) == 0) lim = $urandom_range(15);
        if ($urandom_range(3) == 0) md = $urandom_range(3);
        drive($urandom_range(31) == 0, $urandom_range(9) == 0, $urandom_range(15),
              $urandom_range(3) != 0, lim, md, $urandom_range(1) == 1);
        tick("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised, programmable-sequence counter for the lab timing and sequence-generation blocks. It counts up from 0 to a run-time limit with a selectable increment pattern, including a warm-up pattern of +1, +1, then +STEP. It supports synchronous load, enable gating and a registered wrap pulse. An optional down-count direction is compiled in by macro.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..16.
- STEP, 2: large increment; legal range 1..2**WIDTH-1.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; highest priority.
- en  input  1  advance the counter this cycle.
- load  input  1  load `load_val` this cycle; overrides `en`.
- load_val  input  WIDTH  value loaded on `load`.
- limit  input  WIDTH  terminal value; sampled every cycle.
- mode  input  2  increment pattern: 0 = +1, 1 = +STEP, 2 = warm-up, 3 = reserved (behaves as 0).
- dir  input  1  0 = up, 1 = down; only effective with `STEP_COUNTER_DOWN_EN`.
- cnt  output  WIDTH  registered count.
- wrap  output  1  registered one-cycle pulse on wrap-around.
- at_limit  output  1  combinational `cnt == limit`.

## Operation
- Priority per clock edge: reset, then load, then en, then hold.
- Reset: `cnt` = 0 and `wrap` = 0.
- Load: `cnt` = `load_val` and `wrap` = 0. No range check is applied, so `load_val` may exceed `limit`.
- Hold (en = 0, load = 0): `cnt` is unchanged and `wrap` = 0.
- Increment `inc` by mode:
  - Mode 0: 1.
  - Mode 1: STEP.
  - Mode 2 (warm-up): 1 while `cnt` < 2, otherwise STEP.
- Up count, en = 1:
  - If `cnt` >= `limit`: `cnt` becomes 0 and `wrap` = 1.
  - Otherwise, compute `cnt + inc` in WIDTH+1 bits. If the result is greater than `limit`, `cnt` becomes `limit` (clamp, so the limit is always visited). Otherwise `cnt` becomes the sum.
- Limit of 0 with en held high: `cnt` stays 0 and `wrap` pulses every cycle.
- Mode or limit changes take effect on the next enabled edge. There is no internal state other than `cnt` and `wrap`.
- The FSM is implicit in the value of `cnt`: COUNT (`cnt` < `limit`), TERMINAL (`cnt` >= `limit`). The TERMINAL→COUNT transition on `en` produces `wrap`.

## Timing
- Latency from a sampled `en`, `load` or `reset` to `cnt` is one cycle.
- `wrap` is asserted in the same cycle that `cnt` first shows the wrapped value (0 going up, `limit` going down). It is high for exactly one cycle per wrap.
- `at_limit` follows `cnt` and `limit` with no register. It may glitch when `limit` changes.
- Back-to-back enabled cycles give one count per clock. No throughput gaps.
- Reset asserted mid-count is honoured on the next edge regardless of `en` or `load`.

## Configuration
- `STEP_COUNTER_DOWN_EN` defined: `dir` = 1 selects the down count.
  - If `cnt` = 0 or `cnt` > `limit`: `cnt` becomes `limit` and `wrap` = 1.
  - Otherwise `cnt` becomes `cnt - inc`, clamped at 0.
  - In the down direction, mode 2 behaves as mode 1.
- Macro undefined: the `dir` port remains but is ignored and the block counts up only. The down-count logic must not be synthesised.

## Structure
- Shared package `step_counter_pkg`:
  - Mode encoding constants MODE_UNIT = 0, MODE_STEP = 1, MODE_WARMUP = 2.
  - The 2-bit mode typedef.
- Sub-module `step_counter_next`: combinational next-value and wrap calculation from `cnt`, `limit`, `mode`, `dir`. The top module holds only the registers and the reset/load/en priority.

## Test plan
All scenarios use WIDTH=4 and STEP=2.
- Reset, then mode 2, limit 14, en held high: `cnt` = 0,1,2,4,6,8,10,12,14,0. `wrap` pulses only with the final 0. `at_limit` is high only at 14.
- Mode 1, limit 13, en high from 0: `cnt` = 0,2,…,12,13 (clamp), then 0 with `wrap`.
- Load 15 with limit 9, then en: `cnt` = 15, then 0 with `wrap`. Load while en = 1 takes the load value.
- en toggling 1/0 in mode 0, limit 3: `cnt` advances only on enabled edges. Reset asserted mid-count forces 0 on the next edge with `wrap` = 0.
- Limit 0 with en high: `cnt` stays 0 and `wrap` is high every cycle. Changing `limit` to 5 resumes normal counting from the next edge.
- With `STEP_COUNTER_DOWN_EN`, dir = 1, mode 1, limit 7, start 0: `cnt` = 7 (with `wrap`), 5, 3, 1, 0, 7 (with `wrap`).
